// File: rtl/ghr_ckpt_ctrl.sv
// Speculative global-history controller with per-branch checkpoints in a circular buffer.
// Optional illegal-event flag enabled by defining GHR_CKPT_CHECK_EN.
module ghr_ckpt_ctrl #(
  parameter int HIST_W = 10,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [TAG_W-1:0]  pred_tag,
  input  logic              retire_valid,
  input  logic              mispredict_valid,
  input  logic [TAG_W-1:0]  mispredict_tag,
  input  logic              mispredict_taken,
  output logic [HIST_W-1:0] history,
  output logic [TAG_W:0]    count,
  output logic              ckpt_err
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);

  logic [HIST_W-1:0] ckpt [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [TAG_W-1:0]  mp_off;
  logic              full, mp_in_win, mp, ret, alloc;

  assign full       = (count == FULL_CNT);
  assign pred_ready = !full && !mispredict_valid;
  assign pred_tag   = tail;
  assign alloc      = pred_valid && pred_ready;
  assign ret        = retire_valid && (count != '0);

  // Age of the mispredicted tag relative to head; in the window iff younger than count.
  assign mp_off    = mispredict_tag - head;
  assign mp_in_win = (count != '0) && ({1'b0, mp_off} < count);
  assign mp        = mispredict_valid && mp_in_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (mp) begin
      history <= {ckpt[mispredict_tag][HIST_W-2:0], mispredict_taken};
      tail    <= mispredict_tag + TAG_ONE;
      head    <= head + TAG_W'(ret);
      // (tag - head') + 1 with head' = head + ret; zero when retire frees the tag itself
      count   <= ({1'b0, mp_off} + CNT_ONE) - (TAG_W+1)'(ret);
    end else begin
      if (alloc)
        history <= {history[HIST_W-2:0], pred_taken};
      head  <= head + TAG_W'(ret);
      tail  <= tail + TAG_W'(alloc);
      count <= count + (TAG_W+1)'(alloc) - (TAG_W+1)'(ret);
    end
  end

  // Checkpoint storage is data only: no reset, validity tracked by head/tail.
  always_ff @(posedge clk) begin
    if (alloc)
      ckpt[tail] <= history;
  end

`ifdef GHR_CKPT_CHECK_EN
  logic err_ev;
  assign err_ev = (retire_valid && (count == '0)) ||
                  (mispredict_valid && !mp_in_win) ||
                  (pred_valid && full && !mispredict_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ckpt_err <= 1'b0;
    else if (err_ev)
      ckpt_err <= 1'b1;
  end
`else
  assign ckpt_err = 1'b0;
`endif

endmodule

// File: tb/tb_ghr_ckpt_ctrl.sv
// Directed bench for ghr_ckpt_ctrl with hand-computed expected history/tag/count values.
module tb_ghr_ckpt_ctrl;

  localparam int HIST_W = 10;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
`ifdef GHR_CKPT_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              pred_valid = 1'b0, pred_taken = 1'b0, pred_ready;
  logic [TAG_W-1:0]  pred_tag;
  logic              retire_valid = 1'b0;
  logic              mispredict_valid = 1'b0, mispredict_taken = 1'b0;
  logic [TAG_W-1:0]  mispredict_tag = '0;
  logic [HIST_W-1:0] history;
  logic [TAG_W:0]    count;
  logic              ckpt_err;

  int checks = 0;
  int failures = 0;

  ghr_ckpt_ctrl #(.HIST_W(HIST_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .pred_tag(pred_tag),
    .retire_valid(retire_valid),
    .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
    .mispredict_taken(mispredict_taken),
    .history(history), .count(count), .ckpt_err(ckpt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pred_valid = 1'b0; retire_valid = 1'b0; mispredict_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic taken);
    pred_valid = 1'b1; pred_taken = taken;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic retire();
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    step();
    reset = 1'b0;
    check("rst_history", 32'(history), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ready", 32'(pred_ready), 32'h1);
    check("rst_tag", 32'(pred_tag), 32'h0);
    check("rst_err", 32'(ckpt_err), 32'h0);

    // Allocate T,N,T -> tags 0,1,2; history 101
    check("t1_tag0", 32'(pred_tag), 32'd0);
    alloc(1'b1);
    check("t1_tag1", 32'(pred_tag), 32'd1);
    alloc(1'b0);
    check("t1_tag2", 32'(pred_tag), 32'd2);
    alloc(1'b1);
    check("t1_history", 32'(history), 32'b101);
    check("t1_count", 32'(count), 32'd3);
    // Asynchronous reset clears state before the next clock edge
    reset = 1'b1;
    #1;
    check("t1_async_hist", 32'(history), 32'h0);
    check("t1_async_count", 32'(count), 32'h0);
    step();
    reset = 1'b0;

    // Fill to DEPTH, then a held pred_valid is refused
    for (int i = 0; i < DEPTH; i++) alloc(1'b1);
    check("t2_count_full", 32'(count), 32'd8);
    check("t2_ready_full", 32'(pred_ready), 32'd0);
    check("t2_hist_full", 32'(history), 32'h0FF);
    pred_valid = 1'b1; pred_taken = 1'b0;
    step();
    check("t2_count_9th", 32'(count), 32'd8);
    check("t2_hist_9th", 32'(history), 32'h0FF);
    check("t2_tag_wrap", 32'(pred_tag), 32'd0);
    retire_valid = 1'b1;
    step();
    retire_valid = 1'b0; pred_valid = 1'b0;
    check("t2_count_ret", 32'(count), 32'd7);
    check("t2_ready_ret", 32'(pred_ready), 32'd1);
    check("t2_hist_ret", 32'(history), 32'h0FF);
    check("t2_err", 32'(ckpt_err), 32'(CHK));

    // Mispredict tag 2 among tags 0..4 (T,T,N,T,N): H2 = 0b11
    do_reset();
    alloc(1'b1); alloc(1'b1); alloc(1'b0); alloc(1'b1); alloc(1'b0);
    check("t3_hist_pre", 32'(history), 32'b11010);
    mispredict_valid = 1'b1; mispredict_tag = 3'd2; mispredict_taken = 1'b0;
    pred_valid = 1'b1; pred_taken = 1'b1;
    #1;
    check("t3_ready_mp", 32'(pred_ready), 32'd0);
    step();
    mispredict_valid = 1'b0; pred_valid = 1'b0;
    check("t3_hist_mp", 32'(history), 32'b110);
    check("t3_count_mp", 32'(count), 32'd3);
    check("t3_tag_mp", 32'(pred_tag), 32'd3);
    check("t3_err", 32'(ckpt_err), 32'd0);

    // Wrap: head=6, allocate tags 6,7,0,1 (T,N,T,T), mispredict tag 7
    do_reset();
    for (int i = 0; i < 6; i++) alloc(1'b0);
    for (int i = 0; i < 6; i++) retire();
    check("t4_count_empty", 32'(count), 32'd0);
    check("t4_tag6", 32'(pred_tag), 32'd6);
    alloc(1'b1); alloc(1'b0);
    check("t4_tag0", 32'(pred_tag), 32'd0);
    alloc(1'b1); alloc(1'b1);
    check("t4_hist_pre", 32'(history), 32'b1011);
    mispredict_valid = 1'b1; mispredict_tag = 3'd7; mispredict_taken = 1'b0;
    step();
    mispredict_valid = 1'b0;
    check("t4_count_mp", 32'(count), 32'd2);
    check("t4_tag_mp", 32'(pred_tag), 32'd0);
    check("t4_hist_mp", 32'(history), 32'b10);

    // Retire head=4 together with mispredict of tag 4
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b0);
    for (int i = 0; i < 4; i++) retire();
    alloc(1'b1); alloc(1'b1); alloc(1'b0);
    check("t5_count_pre", 32'(count), 32'd3);
    retire_valid = 1'b1; mispredict_valid = 1'b1;
    mispredict_tag = 3'd4; mispredict_taken = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'b0;
    step();
    retire_valid = 1'b0; mispredict_valid = 1'b0; pred_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_tag", 32'(pred_tag), 32'd5);
    check("t5_hist", 32'(history), 32'b1);
    alloc(1'b0);
    retire();
    check("t5_head_follow", 32'(count), 32'd0);
    check("t5_tag_after", 32'(pred_tag), 32'd6);

    // Illegal events: retire on empty, mispredict outside window {0,1}
    do_reset();
    retire();
    check("t6_count_empty_ret", 32'(count), 32'd0);
    check("t6_err_ret", 32'(ckpt_err), 32'(CHK));
    do_reset();
    alloc(1'b1); alloc(1'b1);
    mispredict_valid = 1'b1; mispredict_tag = 3'd6; mispredict_taken = 1'b0;
    step();
    mispredict_valid = 1'b0;
    check("t6_hist_bad", 32'(history), 32'b11);
    check("t6_count_bad", 32'(count), 32'd2);
    check("t6_tag_bad", 32'(pred_tag), 32'd2);
    check("t6_err_bad", 32'(ckpt_err), 32'(CHK));
    mispredict_valid = 1'b1; mispredict_tag = 3'd2; mispredict_taken = 1'b1;
    step();
    mispredict_valid = 1'b0;
    check("t6_count_tail", 32'(count), 32'd2);
    check("t6_hist_tail", 32'(history), 32'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
